// File: rtl/ps2_key_tracker_if.sv
// Bundle between the PS/2 receiver FIFO and the key tracker.
// The master side is the receiver or any other source of bytes; the slave side is the tracker.
interface ps2_key_tracker_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       i_ps2_data;
  logic             i_ps2_ready;
  logic             i_ps2_overflow;
  logic             o_nextdata_n;
  logic [7:0]       o_key_code;
  logic             o_key_ext;
  logic             o_key_valid;
  logic             o_key_event;
  logic [CNT_W-1:0] o_key_count;
  logic             o_sync_err;

  modport master (
    output i_ps2_data, i_ps2_ready, i_ps2_overflow,
    input  o_nextdata_n, o_key_code, o_key_ext, o_key_valid, o_key_event,
           o_key_count, o_sync_err
  );

  modport slave (
    input  i_ps2_data, i_ps2_ready, i_ps2_overflow,
    output o_nextdata_n, o_key_code, o_key_ext, o_key_valid, o_key_event,
           o_key_count, o_sync_err
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// Pops PS/2 scan codes from the receiver FIFO, decodes make/break/E0 sequences, tracks the held
// key and counts distinct presses. Define PS2_KEY_EXT_EN to enable E0 (extended) key tracking.
module ps2_key_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  ps2_key_tracker_if.slave bus
);
  typedef enum logic [1:0] {HS_WAIT, HS_POP, HS_GUARD} hs_state_t;
  typedef enum logic [1:0] {DEC_NORM, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_t;

  hs_state_t        hs_reg, hs_next;
  dec_state_t       dec_reg, dec_next;
  logic             nextdata_n_reg, nextdata_n_next;
  logic [7:0]       code_reg, code_next;
  logic             ext_reg, ext_next;
  logic             valid_reg, valid_next;
  logic             event_reg, event_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             sync_err_reg, sync_err_next;
  logic             take;
  logic             in_break;
  logic             byte_ext;
  logic             same_key;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      hs_reg         <= HS_WAIT;
      dec_reg        <= DEC_NORM;
      nextdata_n_reg <= 1'b1;
      code_reg       <= 8'h00;
      ext_reg        <= 1'b0;
      valid_reg      <= 1'b0;
      event_reg      <= 1'b0;
      count_reg      <= '0;
      sync_err_reg   <= 1'b0;
    end else begin
      hs_reg         <= hs_next;
      dec_reg        <= dec_next;
      nextdata_n_reg <= nextdata_n_next;
      code_reg       <= code_next;
      ext_reg        <= ext_next;
      valid_reg      <= valid_next;
      event_reg      <= event_next;
      count_reg      <= count_next;
      sync_err_reg   <= sync_err_next;
    end
  end

  always_comb begin
    hs_next         = hs_reg;
    dec_next        = dec_reg;
    nextdata_n_next = 1'b1;
    code_next       = code_reg;
    ext_next        = ext_reg;
    valid_next      = valid_reg;
    event_next      = 1'b0;
    count_next      = count_reg;
    sync_err_next   = sync_err_reg;
    take            = 1'b0;

    // The pop strobe is registered, so it is low exactly during the HS_POP cycle.
    case (hs_reg)
      HS_WAIT: begin
        if (bus.i_ps2_ready) begin
          take            = 1'b1;
          hs_next         = HS_POP;
          nextdata_n_next = 1'b0;
        end
      end
      HS_POP:  hs_next = HS_GUARD;
      default: hs_next = HS_WAIT;
    endcase

    in_break = (dec_reg == DEC_BRK) || (dec_reg == DEC_EXT_BRK);
    byte_ext = (dec_reg == DEC_EXT) || (dec_reg == DEC_EXT_BRK);
    same_key = valid_reg && (bus.i_ps2_data == code_reg) && (byte_ext == ext_reg);

    // Overflow wins over a byte taken at the same edge: that byte is popped but dropped.
    if (bus.i_ps2_overflow) begin
      dec_next      = DEC_NORM;
      valid_next    = 1'b0;
      sync_err_next = 1'b1;
    end else if (take) begin
      if (bus.i_ps2_data == 8'hE0) begin
`ifdef PS2_KEY_EXT_EN
        if (dec_reg == DEC_NORM) begin
          dec_next = DEC_EXT;
        end
`endif
      end else if (bus.i_ps2_data == 8'hF0) begin
        if (dec_reg == DEC_NORM) begin
          dec_next = DEC_BRK;
        end else if (dec_reg == DEC_EXT) begin
          dec_next = DEC_EXT_BRK;
        end
      end else begin
        dec_next = DEC_NORM;
        if (in_break) begin
          if (same_key) begin
            valid_next = 1'b0;
          end
        end else if (!same_key) begin
          code_next  = bus.i_ps2_data;
          ext_next   = byte_ext;
          valid_next = 1'b1;
          count_next = count_reg + 1'b1;
          event_next = 1'b1;
        end
      end
    end
  end

  assign bus.o_nextdata_n = nextdata_n_reg;
  assign bus.o_key_code   = code_reg;
  assign bus.o_key_valid  = valid_reg;
  assign bus.o_key_event  = event_reg;
  assign bus.o_key_count  = count_reg;
  assign bus.o_sync_err   = sync_err_reg;
`ifdef PS2_KEY_EXT_EN
  assign bus.o_key_ext    = ext_reg;
`else
  assign bus.o_key_ext    = 1'b0;
`endif
endmodule
